// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: starts the selected unit, waits for its stop, then loads HI/LO.
// Raises one-cycle divide-by-zero and timeout exception pulses; abort returns to idle.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic             i_op,
  input  logic [31:0]      i_b_operand,
  input  logic             i_abort,
  input  logic             i_mult_stop,
  input  logic             i_div_stop,
  input  logic             i_div_zero,
  output logic             o_mult_init,
  output logic             o_div_init,
  output logic             o_hilo_sel,
  output logic             o_high_load,
  output logic             o_low_load,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero_exc,
  output logic             o_timeout_exc,
  output logic [CNT_W-1:0] o_last_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_EXC   = 3'd5;

  localparam logic KIND_ZERO    = 1'b0;
  localparam logic KIND_TIMEOUT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nx;
  logic             r_op;
  logic             w_op_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_exc_kind;
  logic             w_exc_kind_nx;
  logic [CNT_W-1:0] r_last_cycles;
  logic [CNT_W-1:0] w_last_nx;
  logic             w_sel_stop;
  logic             w_div_by_zero_req;

  assign w_sel_stop        = r_op ? i_div_stop : i_mult_stop;
  assign w_div_by_zero_req = i_op & (i_b_operand == 32'd0);

  // Next-state and datapath-register update logic
  always_comb begin
    w_state_nx    = r_state;
    w_op_nx       = r_op;
    w_cnt_nx      = r_cnt;
    w_exc_kind_nx = r_exc_kind;
    w_last_nx     = r_last_cycles;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_req) begin
          if (w_div_by_zero_req) begin
            w_state_nx    = S_EXC;
            w_exc_kind_nx = KIND_ZERO;
          end else begin
            w_op_nx    = i_op;
            w_state_nx = S_INIT;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_INIT: begin
        if (i_abort) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx   = {CNT_W{1'b0}};
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        // Unit-reported zero outranks its stop; a stop in the last RUN cycle beats timeout
        if (i_abort) begin
          w_state_nx = S_IDLE;
        end else if (r_op && i_div_zero) begin
          w_state_nx    = S_EXC;
          w_exc_kind_nx = KIND_ZERO;
        end else if (w_sel_stop) begin
          w_state_nx = S_WRITE;
          w_last_nx  = r_cnt + CNT_ONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx    = S_EXC;
          w_exc_kind_nx = KIND_TIMEOUT;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      S_WRITE: begin
        if (i_abort) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      S_EXC: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_op          <= 1'b0;
      r_cnt         <= {CNT_W{1'b0}};
      r_exc_kind    <= KIND_ZERO;
      r_last_cycles <= {CNT_W{1'b0}};
    end else begin
      r_state       <= w_state_nx;
      r_op          <= w_op_nx;
      r_cnt         <= w_cnt_nx;
      r_exc_kind    <= w_exc_kind_nx;
      r_last_cycles <= w_last_nx;
    end
  end

  // Outputs decode from registered state; loads and exception pulses are gated by abort
  assign o_busy         = (r_state == S_INIT) | (r_state == S_RUN) |
                          (r_state == S_WRITE) | (r_state == S_EXC);
  assign o_mult_init    = (r_state == S_INIT) & ~r_op;
  assign o_div_init     = (r_state == S_INIT) & r_op;
  assign o_hilo_sel     = r_op;
  assign o_high_load    = (r_state == S_WRITE) & ~i_abort;
  assign o_low_load     = (r_state == S_WRITE) & ~i_abort;
  assign o_done         = (r_state == S_DONE);
  assign o_div_zero_exc = (r_state == S_EXC) & (r_exc_kind == KIND_ZERO) & ~i_abort;
  assign o_timeout_exc  = (r_state == S_EXC) & (r_exc_kind == KIND_TIMEOUT) & ~i_abort;
  assign o_last_cycles  = r_last_cycles;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the shared multiply/divide resource of the multicycle CPU: accepts a mult or div request from the main control unit, pulses the selected unit's init, waits for its stop, then steers and loads the HI/LO registers. It reports busy/done to the control unit and raises one-cycle exception pulses for division by zero (pre-checked or unit-reported) and for a unit that never stops (timeout). It sits between the control unit, the mult/div units, the HI/LO source muxes and the HI/LO registers.

## Interface
- TIMEOUT_CYCLES, 64, max RUN cycles before timeout_exc; 2..2^CNT_W
- CNT_W, 8, width of cycle counter and last_cycles
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req  in  1  operation request; sampled only in IDLE/DONE
- op  in  1  0 = mult, 1 = div; sampled with req
- b_operand  in  32  divisor (B register); sampled with req
- abort  in  1  cancel current operation
- mult_stop  in  1  multiplier finished
- div_stop  in  1  divider finished
- div_zero  in  1  divider reports divide-by-zero
- mult_init  out  1  one-cycle start pulse to multiplier
- div_init  out  1  one-cycle start pulse to divider
- hilo_sel  out  1  HI/LO source mux select, = latched op (0 mult, 1 div)
- high_load, low_load  out  1  HI/LO register load enables
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse
- timeout_exc  out  1  one-cycle timeout exception pulse
- last_cycles  out  CNT_W  RUN-cycle count of last completed operation

## Operation
- States: IDLE, INIT, RUN, WRITE, DONE, EXC. Registers: op_q, cnt, exc_kind, last_cycles.
- IDLE/DONE: busy=0. On req: op=1 and b_operand==0 -> EXC (kind zero), no init issued; else latch op_q, -> INIT. DONE with no req -> IDLE.
- INIT: mult_init = ~op_q, div_init = op_q; cnt <= 0; -> RUN. Stop/zero inputs ignored.
- RUN: priority order: (1) op_q=1 and div_zero -> EXC (kind zero); (2) stop of selected unit (mult_stop if op_q=0, div_stop if op_q=1) -> WRITE, last_cycles <= cnt+1; (3) cnt==TIMEOUT_CYCLES-1 -> EXC (kind timeout); (4) else cnt <= cnt+1, stay. Stop of the non-selected unit ignored.
- WRITE: high_load = low_load = ~abort (combinational gating); -> DONE.
- DONE: done=1 for the one cycle.
- EXC: div_zero_exc or timeout_exc per exc_kind for one cycle; -> IDLE. No HI/LO loads on any exception path.
- busy=1 in INIT, RUN, WRITE, EXC.
- hilo_sel = op_q in all states (stable before and during WRITE).
- abort in INIT/RUN/WRITE/EXC -> IDLE next cycle; no done, no exception pulse, last_cycles unchanged. abort ignored in IDLE/DONE; abort and req in same IDLE cycle: req accepted.
- All other outputs 0 outside the states named above.

## Timing
- Reset (async, low): state IDLE, op_q=0, cnt=0, last_cycles=0, every output 0 immediately, including mid-RUN.
- req at cycle 0 -> init pulse cycle 1 -> RUN from cycle 2; stop sampled at cycle k -> loads at k+1, done at k+2. Minimum request-to-done: 4 cycles (stop in cycle 2).
- Back-to-back: req in DONE cycle -> INIT next cycle.
- Divisor-zero pre-check: req at cycle 0 -> div_zero_exc at cycle 1.
- Unit div_zero at RUN cycle k -> div_zero_exc at k+1.
- Timeout: no stop -> timeout_exc in cycle TIMEOUT_CYCLES+2. Stop in the final RUN cycle wins over timeout.
- cnt increments only in RUN; never wraps (bounded by TIMEOUT_CYCLES).

## Test plan
- Mult: req op=0 cycle 0, mult_stop cycle 34 -> mult_init cycle 1 only, hilo_sel=0, high_load=low_load=1 cycle 35, done cycle 36, last_cycles=33, div_init never asserted.
- Div pre-check: req op=1, b_operand=0 -> div_zero_exc cycle 1, no div_init, no loads, busy back to 0 cycle 2.
- Div unit zero: req op=1, b_operand=5, div_zero and div_stop both high cycle 5 -> div_zero_exc cycle 6, no loads, no done.
- Timeout: TIMEOUT_CYCLES=8, req op=1, no stops -> timeout_exc cycle 10, busy 0 cycle 11; mult_stop pulse in cycle 4 ignored.
- Abort: abort high in WRITE cycle -> high_load=low_load=0 that cycle, no done, IDLE next; then req op=0 accepted normally; req in DONE cycle -> mult_init next cycle.
- Reset: reset low in RUN cycle 10 -> all outputs 0 asynchronously, last_cycles=0; after release, stop inputs ignored until a new req.
